oled_cursor_overlay: RTL and testbench
======================================

Name: oled_cursor_overlay

Overview:
- Sits between the mouse controller and the OLED display driver, in the same path as the per-pixel colour generator.
- Converts raw mouse coordinates into a clamped 96x64 cursor position.
- Detects left/right click and left double-click as single-cycle pulses.
- Overlays a plus-shaped cursor on the background colour for each pixel_index requested by the display driver, and drives oled_data.

Parameters:
- WIDTH, 96, OLED columns
- HEIGHT, 64, OLED rows
- POS_SHIFT, 0, right-shift applied to mouse x/y before clamping
- ARM, 2, cursor arm length in pixels (plus spans 2*ARM+1)
- CURSOR_COLOR, 16'hFFFF, RGB565 cursor colour (idle)
- PRESS_COLOR, 16'hF800, RGB565 cursor colour while left button held
- DBL_CYCLES, 25000000, double-click window in clk cycles (250 ms at 100 MHz)
- HIDE_CYCLES, 300000000, inactivity cycles before cursor hides (3 s)

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- mouse_xpos  in  12  mouse x from controller
- mouse_ypos  in  12  mouse y from controller
- mouse_left  in  1  left button level
- mouse_right  in  1  right button level
- mouse_new_event  in  1  one-cycle strobe: mouse fields valid
- pixel_index  in  13  pixel requested by display driver (row*96+col)
- bg_color  in  16  background RGB565 for current pixel_index
- cursor_en  in  1  1 = draw cursor
- oled_data  out  16  pixel colour to display driver
- cur_x  out  7  cursor column 0..95
- cur_y  out  6  cursor row 0..63
- left_click  out  1  one-cycle pulse, first left press
- left_dbl_click  out  1  one-cycle pulse, second press inside window
- right_click  out  1  one-cycle pulse, right press
- cursor_visible  out  1  cursor currently shown

Behaviour:
- Single clock domain (clk). pixel_index changes at the display rate; the block samples it every clk.
- Reset (async, rst_n=0):
  - oled_data=0, cur_x=0, cur_y=0, all pulses 0, cursor_visible=1.
  - Click FSM to IDLE; timers cleared; button history cleared.
  - A reset mid-window discards any pending double-click.
- Position:
  - On mouse_new_event, cur_x <= min(mouse_xpos>>POS_SHIFT, WIDTH-1) and cur_y <= min(mouse_ypos>>POS_SHIFT, HEIGHT-1).
  - Visible the cycle after the strobe. Otherwise held.
- Buttons:
  - Sampled only on mouse_new_event into left_q/right_q.
  - Press edge = new level 1 while stored level 0.
  - Pulses assert the cycle after the strobe, for exactly one cycle.
- right_click: pulses on each right press edge; no double-click logic.
- Left click FSM, states IDLE and WAIT:
  - IDLE + left press edge -> left_click pulse, timer=0, go WAIT.
  - WAIT: timer increments each cycle.
  - WAIT + left press edge while timer < DBL_CYCLES -> left_dbl_click pulse only (no left_click), go IDLE.
  - WAIT + timer reaching DBL_CYCLES -> IDLE, no pulse.
  - Press edge and expiry in the same cycle: the press wins, because the compare uses the pre-increment timer.
  - A third press after a double-click counts as a new first click.
- Inactivity:
  - hide counter resets to 0 on every mouse_new_event and increments otherwise, saturating.
  - cursor_visible=0 once the counter reaches HIDE_CYCLES.
  - The next new_event sets cursor_visible=1 on the following cycle.
- Pixel path, 1-cycle registered latency:
  - col = pixel_index % WIDTH, row = pixel_index / WIDTH.
  - hit = (col==cur_x && |row-cur_y|<=ARM) || (row==cur_y && |col-cur_x|<=ARM).
  - Differences are computed signed, so the cursor clips at borders and never wraps across rows.
  - oled_data <= 0 if pixel_index >= WIDTH*HEIGHT.
  - Else oled_data <= (PRESS_COLOR if left_q else CURSOR_COLOR) when hit && cursor_en && cursor_visible.
  - Else oled_data <= bg_color.
  - The cursor position used is the value registered at the cycle pixel_index is sampled.

Decomposition:
- Shared package oled_pkg: WIDTH, HEIGHT, NUM_PIXELS=6144, RGB565 constants BLACK, WHITE, RED, GREEN.
- The click FSM state typedef (IDLE/WAIT) stays local.
- One sub-module: click_detector.
  - Inputs: clk, rst_n, strobe, left, right.
  - Outputs: left_click, left_dbl_click, right_click, left_level.
  - Parameter: DBL_CYCLES.
- The top does position clamp, hide counter and pixel overlay.

Test Plan:
Benches use DBL_CYCLES=100 and HIDE_CYCLES=1000.
- Reset, then new_event with xpos=200, ypos=10 -> cur_x=95, cur_y=10 next cycle; xpos=40, ypos=70 -> cur_x=40, cur_y=63.
- cur=(40,10), cursor_en=1, bg_color=16'h07E0: sweep pixel_index -> oled_data=16'hFFFF one cycle after indices 10*96+38..42 and 8*96+40..12*96+40 (step 96); all others 16'h07E0; index 6144 -> 0.
- cur=(0,0) -> cursor pixels at indices 0,1,2,96,192 only; index 95 (row 0, col 95) stays bg; no wrap.
- Left press strobe, release strobe, press again 50 cycles after the first -> left_click once, left_dbl_click once, no second left_click. Repeat with the second press at 150 cycles -> two left_click pulses, no dbl.
- No new_event for 1000 cycles -> cursor_visible=0 and cursor pixels show bg. One new_event -> cursor_visible=1 the next cycle. Left held -> cursor pixels 16'hF800.
- rst_n low for 1 cycle mid-WAIT (timer=40), then press -> left_click (not dbl); all outputs 0 during reset.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared OLED geometry, RGB565 colour constants and a small helper for the cursor hit test.
package oled_pkg;

    localparam int WIDTH      = 96;
    localparam int HEIGHT     = 64;
    localparam int NUM_PIXELS = 6144;

    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] GREEN = 16'h07E0;

    // True when a signed pixel offset lies within +/-arm of the cursor centre.
    function automatic logic within_arm(input logic signed [13:0] d, input int arm);
        return (d <= arm) && (d >= -arm);
    endfunction

endpackage

// File: rtl/click_detector.sv
// Mouse button edge detection with a left double-click window.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no left click pending; a press edge is a first click
//   WAIT  | first click seen; timer counts toward the double-click window
module click_detector #(
    parameter int DBL_CYCLES = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    input  logic left,
    input  logic right,
    output logic left_click,
    output logic left_dbl_click,
    output logic right_click,
    output logic left_level
);

    localparam int TW = $clog2(DBL_CYCLES + 1);

    typedef enum logic {IDLE, WAIT} click_state_t;

    click_state_t  state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          left_q, right_q;
    logic          left_edge;
    logic          lc_nx, dbl_nx;

    assign left_edge  = strobe & left & ~left_q;
    assign left_level = left_q;

    // Next-state, timer and pulse decode; the window compare uses the pre-increment timer.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        lc_nx    = 1'b0;
        dbl_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (left_edge) begin
                    lc_nx    = 1'b1;
                    timer_nx = '0;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                timer_nx = timer + 1'b1;
                if (left_edge && (timer < TW'(DBL_CYCLES))) begin
                    dbl_nx   = 1'b1;
                    timer_nx = '0;
                    state_nx = IDLE;
                end else if (timer >= TW'(DBL_CYCLES - 1)) begin
                    timer_nx = '0;
                    state_nx = IDLE;
                end
            end
            default: begin
                timer_nx = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // State, timer, button history and registered one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            timer          <= '0;
            left_q         <= 1'b0;
            right_q        <= 1'b0;
            left_click     <= 1'b0;
            left_dbl_click <= 1'b0;
            right_click    <= 1'b0;
        end else begin
            state          <= state_nx;
            timer          <= timer_nx;
            left_click     <= lc_nx;
            left_dbl_click <= dbl_nx;
            right_click    <= strobe & right & ~right_q;
            if (strobe) begin
                left_q  <= left;
                right_q <= right;
            end
        end
    end

endmodule

// File: rtl/oled_cursor_overlay.sv
// Cursor position clamp, inactivity hide and plus-shaped cursor overlay onto the OLED pixel stream.
module oled_cursor_overlay #(
    parameter int          WIDTH        = oled_pkg::WIDTH,
    parameter int          HEIGHT       = oled_pkg::HEIGHT,
    parameter int          POS_SHIFT    = 0,
    parameter int          ARM          = 2,
    parameter logic [15:0] CURSOR_COLOR = oled_pkg::WHITE,
    parameter logic [15:0] PRESS_COLOR  = oled_pkg::RED,
    parameter int          DBL_CYCLES   = 25000000,
    parameter int          HIDE_CYCLES  = 300000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        mouse_right,
    input  logic        mouse_new_event,
    input  logic [12:0] pixel_index,
    input  logic [15:0] bg_color,
    input  logic        cursor_en,
    output logic [15:0] oled_data,
    output logic [6:0]  cur_x,
    output logic [5:0]  cur_y,
    output logic        left_click,
    output logic        left_dbl_click,
    output logic        right_click,
    output logic        cursor_visible
);

    import oled_pkg::*;

    logic [11:0]        sx, sy;
    logic [31:0]        hide_cnt;
    logic               left_level;
    logic [12:0]        col, row;
    logic signed [13:0] dx, dy;
    logic               hit;

    click_detector #(.DBL_CYCLES(DBL_CYCLES)) u_click (
        .clk            (clk),
        .rst_n          (rst_n),
        .strobe         (mouse_new_event),
        .left           (mouse_left),
        .right          (mouse_right),
        .left_click     (left_click),
        .left_dbl_click (left_dbl_click),
        .right_click    (right_click),
        .left_level     (left_level)
    );

    assign sx = mouse_xpos >> POS_SHIFT;
    assign sy = mouse_ypos >> POS_SHIFT;

    // Latch the clamped cursor position on each mouse event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x <= '0;
            cur_y <= '0;
        end else if (mouse_new_event) begin
            cur_x <= (sx > 12'(WIDTH - 1))  ? 7'(WIDTH - 1)  : sx[6:0];
            cur_y <= (sy > 12'(HEIGHT - 1)) ? 6'(HEIGHT - 1) : sy[5:0];
        end
    end

    // Inactivity counter: cleared by mouse events, saturates at the hide threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hide_cnt <= '0;
        else if (mouse_new_event)
            hide_cnt <= '0;
        else if (hide_cnt < 32'(HIDE_CYCLES))
            hide_cnt <= hide_cnt + 32'd1;
    end

    assign cursor_visible = (hide_cnt < 32'(HIDE_CYCLES));

    // Signed offsets keep the plus from wrapping into neighbouring rows at the borders.
    always_comb begin
        col = pixel_index % 13'(WIDTH);
        row = pixel_index / 13'(WIDTH);
        dx  = $signed({1'b0, col}) - $signed({7'd0, cur_x});
        dy  = $signed({1'b0, row}) - $signed({8'd0, cur_y});
        hit = ((dx == 14'sd0) && within_arm(dy, ARM)) ||
              ((dy == 14'sd0) && within_arm(dx, ARM));
    end

    // Registered pixel colour: blank outside the panel, cursor over background when shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            oled_data <= BLACK;
        else if (pixel_index >= 13'(WIDTH * HEIGHT))
            oled_data <= BLACK;
        else if (hit && cursor_en && cursor_visible)
            oled_data <= left_level ? PRESS_COLOR : CURSOR_COLOR;
        else
            oled_data <= bg_color;
    end

endmodule

// File: tb/tb_oled_cursor_overlay.sv
// Directed bench for the cursor overlay: clamp, overlay sweep, clicks, hide timeout and reset.
module tb_oled_cursor_overlay;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] mouse_xpos = '0;
    logic [11:0] mouse_ypos = '0;
    logic        mouse_left = 1'b0;
    logic        mouse_right = 1'b0;
    logic        mouse_new_event = 1'b0;
    logic [12:0] pixel_index = '0;
    logic [15:0] bg_color = 16'h07E0;
    logic        cursor_en = 1'b1;
    logic [15:0] oled_data;
    logic [6:0]  cur_x;
    logic [5:0]  cur_y;
    logic        left_click, left_dbl_click, right_click, cursor_visible;

    int n_assert = 0;
    int n_fail   = 0;
    int n_lc = 0, n_dbl = 0;
    int lc0, dbl0;

    oled_cursor_overlay #(.DBL_CYCLES(100), .HIDE_CYCLES(1000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mouse_xpos      (mouse_xpos),
        .mouse_ypos      (mouse_ypos),
        .mouse_left      (mouse_left),
        .mouse_right     (mouse_right),
        .mouse_new_event (mouse_new_event),
        .pixel_index     (pixel_index),
        .bg_color        (bg_color),
        .cursor_en       (cursor_en),
        .oled_data       (oled_data),
        .cur_x           (cur_x),
        .cur_y           (cur_y),
        .left_click      (left_click),
        .left_dbl_click  (left_dbl_click),
        .right_click     (right_click),
        .cursor_visible  (cursor_visible)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle; each one-cycle pulse is seen exactly once.
    always @(negedge clk) begin
        if (left_click)     n_lc++;
        if (left_dbl_click) n_dbl++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int x, input int y, input logic l, input logic r);
        @(negedge clk);
        mouse_xpos      = 12'(x);
        mouse_ypos      = 12'(y);
        mouse_left      = l;
        mouse_right     = r;
        mouse_new_event = 1'b1;
        @(posedge clk);
        #1;
        mouse_new_event = 1'b0;
    endtask

    task automatic pix(input string tag, input int idx, input logic [15:0] exp);
        @(negedge clk);
        pixel_index = 13'(idx);
        @(posedge clk);
        #1;
        chk(tag, oled_data, exp);
    endtask

    function automatic logic sweep_hit(input int idx);
        return (idx >= 998 && idx <= 1002) || idx == 808 || idx == 904 ||
               idx == 1096 || idx == 1192;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1;
        chk("reset_oled", oled_data, 16'h0);
        chk("reset_curx", 16'(cur_x), 16'd0);
        chk("reset_cury", 16'(cur_y), 16'd0);
        chk("reset_vis", 16'(cursor_visible), 16'd1);
        chk("reset_pulses", 16'({left_click, left_dbl_click, right_click}), 16'd0);
        idle(2);
        rst_n = 1'b1;

        // Position clamp
        strobe(200, 10, 1'b0, 1'b0);
        chk("clamp_x95", 16'(cur_x), 16'd95);
        chk("clamp_y10", 16'(cur_y), 16'd10);
        strobe(40, 70, 1'b0, 1'b0);
        chk("clamp_x40", 16'(cur_x), 16'd40);
        chk("clamp_y63", 16'(cur_y), 16'd63);

        // Overlay sweep around cursor (40,10)
        strobe(40, 10, 1'b0, 1'b0);
        for (int i = 700; i <= 1300; i++)
            pix("sweep", i, sweep_hit(i) ? 16'hFFFF : 16'h07E0);
        pix("last_pixel", 6143, 16'h07E0);
        pix("out_of_range", 6144, 16'h0000);
        pix("out_of_range_max", 8191, 16'h0000);

        // Corner cursor: clipped, no wrap to row 0 col 95
        strobe(0, 0, 1'b0, 1'b0);
        pix("corner_0", 0, 16'hFFFF);
        pix("corner_1", 1, 16'hFFFF);
        pix("corner_2", 2, 16'hFFFF);
        pix("corner_96", 96, 16'hFFFF);
        pix("corner_192", 192, 16'hFFFF);
        pix("corner_3", 3, 16'h07E0);
        pix("corner_95", 95, 16'h07E0);
        pix("corner_191", 191, 16'h07E0);
        pix("corner_97", 97, 16'h07E0);
        pix("corner_288", 288, 16'h07E0);

        // Double click inside window
        lc0 = n_lc; dbl0 = n_dbl;
        strobe(0, 0, 1'b1, 1'b0);
        chk("first_click", 16'(left_click), 16'd1);
        chk("first_not_dbl", 16'(left_dbl_click), 16'd0);
        strobe(0, 0, 1'b0, 1'b0);
        idle(48);
        strobe(0, 0, 1'b1, 1'b0);
        chk("dbl_pulse", 16'(left_dbl_click), 16'd1);
        chk("dbl_no_click", 16'(left_click), 16'd0);
        idle(2);
        chk("dbl_one_cycle", 16'(left_dbl_click), 16'd0);
        chk("dbl_count_lc", 16'(n_lc - lc0), 16'd1);
        chk("dbl_count_dbl", 16'(n_dbl - dbl0), 16'd1);

        // Second press well after window: two singles
        strobe(0, 0, 1'b0, 1'b0);
        idle(110);
        lc0 = n_lc; dbl0 = n_dbl;
        strobe(0, 0, 1'b1, 1'b0);
        strobe(0, 0, 1'b0, 1'b0);
        idle(148);
        strobe(0, 0, 1'b1, 1'b0);
        chk("late_click", 16'(left_click), 16'd1);
        strobe(0, 0, 1'b0, 1'b0);
        idle(2);
        chk("late_count_lc", 16'(n_lc - lc0), 16'd2);
        chk("late_count_dbl", 16'(n_dbl - dbl0), 16'd0);

        // Window boundary: press at timer 99 is still a double click
        idle(110);
        strobe(0, 0, 1'b1, 1'b0);
        strobe(0, 0, 1'b0, 1'b0);
        idle(98);
        strobe(0, 0, 1'b1, 1'b0);
        chk("edge99_dbl", 16'(left_dbl_click), 16'd1);
        chk("edge99_no_click", 16'(left_click), 16'd0);
        strobe(0, 0, 1'b0, 1'b0);
        // One cycle later the window has closed
        idle(110);
        strobe(0, 0, 1'b1, 1'b0);
        strobe(0, 0, 1'b0, 1'b0);
        idle(99);
        strobe(0, 0, 1'b1, 1'b0);
        chk("edge100_click", 16'(left_click), 16'd1);
        chk("edge100_no_dbl", 16'(left_dbl_click), 16'd0);
        strobe(0, 0, 1'b0, 1'b0);

        // Third press after a double counts as a new first click
        idle(110);
        strobe(0, 0, 1'b1, 1'b0);
        strobe(0, 0, 1'b0, 1'b0);
        strobe(0, 0, 1'b1, 1'b0);
        chk("quick_dbl", 16'(left_dbl_click), 16'd1);
        strobe(0, 0, 1'b0, 1'b0);
        strobe(0, 0, 1'b1, 1'b0);
        chk("third_click", 16'(left_click), 16'd1);
        chk("third_not_dbl", 16'(left_dbl_click), 16'd0);
        strobe(0, 0, 1'b0, 1'b0);

        // Right click edges
        strobe(0, 0, 1'b0, 1'b1);
        chk("right_press", 16'(right_click), 16'd1);
        strobe(0, 0, 1'b0, 1'b1);
        chk("right_held", 16'(right_click), 16'd0);
        strobe(0, 0, 1'b0, 1'b0);
        strobe(0, 0, 1'b0, 1'b1);
        chk("right_again", 16'(right_click), 16'd1);
        strobe(0, 0, 1'b0, 1'b0);
        idle(110);

        // Inactivity hide
        strobe(40, 10, 1'b0, 1'b0);
        repeat (999) @(posedge clk);
        #1;
        chk("vis_at_999", 16'(cursor_visible), 16'd1);
        @(posedge clk);
        #1;
        chk("hidden_at_1000", 16'(cursor_visible), 16'd0);
        pix("hidden_bg", 1000, 16'h07E0);
        strobe(40, 10, 1'b1, 1'b0);
        chk("vis_restored", 16'(cursor_visible), 16'd1);
        pix("press_color", 1000, 16'hF800);
        pix("press_arm", 1002, 16'hF800);
        @(negedge clk);
        cursor_en = 1'b0;
        pix("cursor_disabled", 1000, 16'h07E0);
        cursor_en = 1'b1;
        strobe(40, 10, 1'b0, 1'b0);
        idle(110);

        // Reset mid-window discards the pending double click
        strobe(40, 10, 1'b1, 1'b0);
        strobe(40, 10, 1'b0, 1'b0);
        idle(38);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_oled", oled_data, 16'h0);
        chk("rst_cur", 16'({cur_x, cur_y}), 16'd0);
        chk("rst_pulses", 16'({left_click, left_dbl_click, right_click}), 16'd0);
        chk("rst_vis", 16'(cursor_visible), 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        strobe(0, 0, 1'b1, 1'b0);
        chk("post_rst_click", 16'(left_click), 16'd1);
        chk("post_rst_no_dbl", 16'(left_dbl_click), 16'd0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
